// File: rtl/voice_mix_scheduler.sv
// Voice mix scheduler: on each sampler request, polls every enabled voice in
// order, sums the returned samples, applies a volume shift with saturation and
// presents the result as a 10-bit offset-binary PWM code.
module voice_mix_scheduler #(
  parameter int NUM_VOICES     = 4,
  parameter int SAMPLE_WIDTH   = 14,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               synth_ready,
  output logic                               synth_valid,
  output logic [9:0]                         scaled_synth_code,
  input  logic [NUM_VOICES-1:0]              voice_enable,
  input  logic [2:0]                         volume_shift,
  output logic [NUM_VOICES-1:0]              voice_req,
  input  logic [NUM_VOICES-1:0]              voice_valid,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples,
  output logic                               busy,
  output logic [NUM_VOICES-1:0]              timeout_flags,
  output logic                               overrun,
  input  logic                               clear_status
);

  localparam int IDXW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACCW = SAMPLE_WIDTH + $clog2(NUM_VOICES) + 1;
  localparam int TOW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDXW-1:0]        LAST_IDX = IDXW'(NUM_VOICES - 1);
  localparam logic [TOW-1:0]         TO_LAST  = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [ACCW-1:0] SAT_HI   = ACCW'(511);
  localparam logic signed [ACCW-1:0] SAT_LO   = ACCW'(-512);

  typedef enum logic [1:0] {IDLE, FETCH, SCALE, OUTPUT} state_t;

  state_t                  state_q;
  logic [IDXW-1:0]         idx_q;
  logic signed [ACCW-1:0]  acc_q;
  logic [TOW-1:0]          toCnt_q;
  logic [NUM_VOICES-1:0]   req_q;
  logic [NUM_VOICES-1:0]   flags_q;
  logic                    overrun_q;
  logic                    valid_q;
  logic [9:0]              code_q;

  logic [SAMPLE_WIDTH-1:0] sampleArr [NUM_VOICES];
  logic [SAMPLE_WIDTH-1:0] curSample_d;
  logic signed [ACCW-1:0]  sampleExt_d;
  logic signed [ACCW-1:0]  shifted_d;
  logic [9:0]              code_d;
  logic [IDXW-1:0]         nextIdx_d;
  logic [NUM_VOICES-1:0]   nextReq_d;
  logic [NUM_VOICES-1:0]   firstReq_d;
  logic [NUM_VOICES-1:0]   flagSet_d;
  logic                    curReq_d;
  logic                    curValid_d;
  logic                    accept_d;
  logic                    timeout_d;
  logic                    advance_d;

  // Unpack the flat sample bus so the current voice can be selected by index
  for (genvar g = 0; g < NUM_VOICES; g++) begin : gUnpack
    assign sampleArr[g] = voice_samples[g*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

  // Handshake decode for the voice under fetch, next-voice request and scaling
  always_comb begin
    curSample_d = sampleArr[idx_q];
    sampleExt_d = {{(ACCW-SAMPLE_WIDTH){curSample_d[SAMPLE_WIDTH-1]}}, curSample_d};
    curReq_d    = req_q[idx_q];
    curValid_d  = voice_valid[idx_q];
    accept_d    = (state_q == FETCH) && curReq_d && curValid_d;
    timeout_d   = (state_q == FETCH) && curReq_d && !curValid_d && (toCnt_q == TO_LAST);
    advance_d   = (state_q == FETCH) && (!curReq_d || curValid_d || (toCnt_q == TO_LAST));
    flagSet_d   = timeout_d ? (NUM_VOICES'(1) << idx_q) : '0;
    nextIdx_d   = idx_q + IDXW'(1);
    nextReq_d   = voice_enable[nextIdx_d] ? (NUM_VOICES'(1) << nextIdx_d) : '0;
    firstReq_d  = voice_enable[0] ? NUM_VOICES'(1) : '0;
    shifted_d   = acc_q >>> volume_shift;
    if (shifted_d > SAT_HI) begin
      code_d = 10'd1023;
    end else if (shifted_d < SAT_LO) begin
      code_d = 10'd0;
    end else begin
      code_d = shifted_d[9:0] ^ 10'h200;
    end
  end

  // Main sequencer: status flags, voice polling, accumulation and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      toCnt_q   <= '0;
      req_q     <= '0;
      flags_q   <= '0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= 10'd512;
    end else begin
      valid_q <= 1'b0;
      flags_q <= (clear_status ? '0 : flags_q) | flagSet_d;
      if (synth_ready && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end else if (clear_status) begin
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (synth_ready) begin
            state_q <= FETCH;
            idx_q   <= '0;
            acc_q   <= '0;
            toCnt_q <= '0;
            req_q   <= firstReq_d;
          end
        end
        FETCH: begin
          if (accept_d) begin
            acc_q <= acc_q + sampleExt_d;
          end
          if (advance_d) begin
            toCnt_q <= '0;
            if (idx_q == LAST_IDX) begin
              state_q <= SCALE;
              req_q   <= '0;
            end else begin
              idx_q <= nextIdx_d;
              req_q <= nextReq_d;
            end
          end else if (curReq_d) begin
            toCnt_q <= toCnt_q + TOW'(1);
          end
        end
        SCALE: begin
          code_q  <= code_d;
          valid_q <= 1'b1;
          state_q <= OUTPUT;
        end
        OUTPUT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign synth_valid       = valid_q;
  assign scaled_synth_code = code_q;
  assign voice_req         = req_q;
  assign busy              = (state_q != IDLE);
  assign timeout_flags     = flags_q;
  assign overrun           = overrun_q;

endmodule
